// File: rtl/assist_mode_ctrl.sv
// eBike assist-level controller: debounced button -> 2-bit setting -> rate-limited 8-bit scale, brake forces scale to 0.
// Long-press-to-off is built only when ASSIST_LONG_OFF_EN is defined; otherwise every press is a short press on release.
module assist_mode_ctrl #(
  parameter logic [19:0] DB_CYCLES   = 20'd500000,
  parameter logic [25:0] LONG_CYCLES = 26'd50000000,
  parameter logic [15:0] RAMP_DIV    = 16'd2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tggleMd,
  input  logic       brake,
  output logic [1:0] setting,
  output logic [7:0] scale,
  output logic       chg
);

  typedef enum logic [1:0] {IDLE, PRESSED, WAIT_REL} state_t;

  if (DB_CYCLES < 20'd2 || RAMP_DIV < 16'd1 || LONG_CYCLES <= 26'(DB_CYCLES)) begin : g_bad_params
    $error("assist_mode_ctrl: illegal parameter combination");
  end

  logic        meta_q, sync_q;
  logic        deb_q, deb_d;
  logic [19:0] dbc_q, dbc_d;
  state_t      state_q, state_d;
  logic [1:0]  setting_q, setting_d;
  logic        chg_q, chg_d;
  logic [7:0]  scale_q, scale_d;
  logic [15:0] rc_q, rc_d;
  logic [7:0]  tgt;
`ifdef ASSIST_LONG_OFF_EN
  logic [25:0] hc_q, hc_d;
`endif

  // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    dbc_d = dbc_q;
    if (sync_q == deb_q) begin
      dbc_d = '0;
    end else if (dbc_q == DB_CYCLES - 20'd1) begin
      deb_d = sync_q;
      dbc_d = '0;
    end else begin
      dbc_d = dbc_q + 20'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    setting_d = setting_q;
`ifdef ASSIST_LONG_OFF_EN
    hc_d      = hc_q;
`endif
    case (state_q)
      IDLE: begin
        if (deb_q) begin
          state_d = PRESSED;
`ifdef ASSIST_LONG_OFF_EN
          hc_d    = '0;
`endif
        end
      end
      PRESSED: begin
`ifdef ASSIST_LONG_OFF_EN
        if (deb_q) begin
          if (hc_q == LONG_CYCLES - 26'd1) begin
            setting_d = 2'd0;
            state_d   = WAIT_REL;
          end else begin
            hc_d = hc_q + 26'd1;
          end
        end else begin
          setting_d = setting_q + 2'd1;
          state_d   = IDLE;
        end
`else
        if (!deb_q) begin
          setting_d = setting_q + 2'd1;
          state_d   = IDLE;
        end
`endif
      end
      WAIT_REL: begin
        if (!deb_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    chg_d = (setting_d != setting_q);
  end

  // Ramp toward setting*85 one LSB per RAMP_DIV cycles; brake overrides any tick.
  always_comb begin
    tgt     = {6'd0, setting_q} * 8'd85;
    scale_d = scale_q;
    rc_d    = rc_q;
    if (brake) begin
      scale_d = '0;
      rc_d    = '0;
    end else if (rc_q == RAMP_DIV - 16'd1) begin
      rc_d = '0;
      if (scale_q < tgt)      scale_d = scale_q + 8'd1;
      else if (scale_q > tgt) scale_d = scale_q - 8'd1;
    end else begin
      rc_d = rc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      deb_q     <= 1'b1;
      dbc_q     <= '0;
      state_q   <= WAIT_REL;
      setting_q <= 2'b10;
      chg_q     <= 1'b0;
      scale_q   <= '0;
      rc_q      <= '0;
`ifdef ASSIST_LONG_OFF_EN
      hc_q      <= '0;
`endif
    end else begin
      meta_q    <= tggleMd;
      sync_q    <= meta_q;
      deb_q     <= deb_d;
      dbc_q     <= dbc_d;
      state_q   <= state_d;
      setting_q <= setting_d;
      chg_q     <= chg_d;
      scale_q   <= scale_d;
      rc_q      <= rc_d;
`ifdef ASSIST_LONG_OFF_EN
      hc_q      <= hc_d;
`endif
    end
  end

  assign setting = setting_q;
  assign scale   = scale_q;
  assign chg     = chg_q;

endmodule

// File: tb/tb_assist_mode_ctrl.sv
// Bench for assist_mode_ctrl: directed scenarios plus random button/brake/reset traffic against a behavioural model.
module tb_assist_mode_ctrl;

  localparam logic [19:0] DB = 20'd4;
  localparam logic [25:0] LG = 26'd16;
  localparam logic [15:0] RD = 16'd2;
`ifdef ASSIST_LONG_OFF_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tggleMd = 1'b0;
  logic       brake = 1'b0;
  logic [1:0] setting;
  logic [7:0] scale;
  logic       chg;

  int checks = 0;
  int errors = 0;
  int chg_total = 0;

  assist_mode_ctrl #(.DB_CYCLES(DB), .LONG_CYCLES(LG), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .tggleMd(tggleMd), .brake(brake),
    .setting(setting), .scale(scale), .chg(chg)
  );

  always #5 clk = ~clk;

  // Behavioural model: button pipeline, stable-run debounce, press bookkeeping, ramp.
  int m_s1 = 0, m_s2 = 0, m_deb = 1, m_run = 0;
  int m_wait = 1, m_held = 0, m_set = 2, m_chg = 0;
  int m_sc = 0, m_tick = 0;

  always @(posedge clk) begin
    int od, os, nset, tgt;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_deb = 1; m_run = 0;
      m_wait = 1; m_held = 0; m_set = 2; m_chg = 0;
      m_sc = 0; m_tick = 0;
    end else begin
      od  = m_deb;
      os  = m_set;
      tgt = os * 85;
      if (m_s2 == m_deb) m_run = 0;
      else begin
        m_run++;
        if (m_run == int'(DB)) begin m_deb = m_s2; m_run = 0; end
      end
      m_s2 = m_s1;
      m_s1 = int'(tggleMd);
      nset = os;
      if (m_wait != 0) begin
        if (od == 0) m_wait = 0;
      end else if (m_held == 0) begin
        if (od != 0) m_held = 1;
      end else if (od != 0) begin
        if (LONG_EN && m_held == int'(LG)) begin nset = 0; m_wait = 1; m_held = 0; end
        else m_held++;
      end else begin
        nset = (os + 1) % 4;
        m_held = 0;
      end
      m_chg = (nset != os) ? 1 : 0;
      m_set = nset;
      if (brake) begin
        m_sc = 0; m_tick = 0;
      end else if (m_tick + 1 == int'(RD)) begin
        m_tick = 0;
        if (m_sc < tgt) m_sc++;
        else if (m_sc > tgt) m_sc--;
      end else begin
        m_tick++;
      end
    end
    #1;
    checks++;
    if (setting !== m_set[1:0] || scale !== m_sc[7:0] || chg !== m_chg[0]) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: dut setting=%0d scale=%0d chg=%0d, model setting=%0d scale=%0d chg=%0d",
               $time, setting, scale, chg, m_set, m_sc, m_chg);
    end
    if (chg === 1'b1) chg_total++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    tggleMd = 1'b1;
    cyc(n);
    tggleMd = 1'b0;
    cyc(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int len;
    #1;
    do_reset();
    chk("reset_setting", setting, 2);
    chk("reset_scale", scale, 0);
    chk("reset_chg", chg, 0);

    cyc(339);
    chk("ramp_339", scale, 169);
    cyc(1);
    chk("ramp_340", scale, 170);
    chk("model_ramp_340", m_sc, 170);
    cyc(50);
    chk("ramp_hold_170", scale, 170);
    chk("no_press_setting", setting, 2);

    base = chg_total;
    press(8);
    chk("short_press_2to3", setting, 3);
    chk("short_press_chg_once", chg_total - base, 1);
    cyc(200);
    chk("ramp_to_255", scale, 255);
    cyc(20);
    chk("ramp_no_wrap", scale, 255);

    base = chg_total;
    for (int i = 0; i < 10; i++) begin
      tggleMd = 1'b1; cyc(1);
      tggleMd = 1'b0; cyc(1);
    end
    chk("bounce_no_press", setting, 3);
    press(8);
    chk("bounce_wrap_3to0", setting, 0);
    chk("bounce_chg_once", chg_total - base, 1);
    cyc(560);
    chk("ramp_down_0", scale, 0);

    press(8);
    chk("press_0to1", setting, 1);
    base = chg_total;
    tggleMd = 1'b1;
    cyc(40);
    chk("long_hold_during", setting, LONG_EN ? 0 : 1);
    tggleMd = 1'b0;
    cyc(12);
    chk("long_after_release", setting, LONG_EN ? 0 : 2);
    chk("long_chg_count", chg_total - base, 1);
    base = chg_total;
    tggleMd = 1'b1;
    cyc(40);
    tggleMd = 1'b0;
    cyc(12);
    chk("long_from_0_setting", setting, LONG_EN ? 0 : 3);
    chk("long_from_0_chg", chg_total - base, LONG_EN ? 0 : 1);

    tggleMd = 1'b1;
    do_reset();
    base = chg_total;
    cyc(20);
    chk("held_through_reset", setting, 2);
    tggleMd = 1'b0;
    cyc(12);
    chk("held_release_nochg", setting, 2);
    chk("held_release_chg", chg_total - base, 0);
    press(8);
    chk("after_held_press", setting, 3);

    do_reset();
    cyc(400);
    chk("pre_brake_170", scale, 170);
    brake = 1'b1;
    cyc(1);
    chk("brake_scale_0", scale, 0);
    press(8);
    chk("brake_press_setting", setting, 3);
    chk("brake_press_scale", scale, 0);
    cyc(5);
    brake = 1'b0;
    cyc(2);
    chk("brake_release_first_step", scale, 1);
    cyc(600);
    chk("brake_release_255", scale, 255);

    for (int i = 0; i < 150; i++) begin
      len     = int'($urandom_range(1, 40));
      tggleMd = 1'($urandom % 2);
      brake   = (($urandom % 6) == 0);
      rst_n   = !(($urandom % 40) == 0);
      cyc(len);
    end
    rst_n = 1'b1;
    brake = 1'b0;
    tggleMd = 1'b0;
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
